memfifo_gearbox: RTL and testbench
==================================

// Module: memfifo_gearbox
// PURPOSE
//  Parametrised datapath between ezusb_io and bram_fifo. Packs RATIO USB words into one FIFO word
//  (EZ-USB -> FPGA) and unpacks FIFO words into USB words (FPGA -> EZ-USB).
//  The write side can also be fed by a built-in counter-pattern generator with a programmable rate.
//  Generalises the fixed 16/32-bit, 2-rate glue to any width ratio and any divider.
// PARAMETERS
//  USB_W   16  USB word width in bits
//  FIFO_W  32  FIFO word width in bits; must equal RATIO*USB_W, RATIO in 2..8
//  DIV_W   4   width of rate_div
// PORTS
//  ifclk          in   1        interface clock; all logic on rising edge
//  reset          in   1        synchronous, active-high
//  mode           in   2        0=USB input, 1=generator full rate, 2=generator divided, 3=write side idle
//  rate_div       in   DIV_W    mode 2: one generator word per rate_div+1 cycles
//  usb_do         in   USB_W    word from EZ-USB
//  usb_do_valid   in   1        usb_do valid
//  usb_do_ready   out  1        usb_do accepted this cycle when valid&ready
//  fifo_di        out  FIFO_W   FIFO write data; held while fifo_full
//  fifo_wren      out  1        FIFO write strobe
//  fifo_full      in   1        FIFO full
//  fifo_do        in   FIFO_W   FIFO read data, valid the cycle after fifo_rden
//  fifo_rden      out  1        FIFO read strobe
//  fifo_empty     in   1        FIFO empty
//  usb_di         out  USB_W    word to EZ-USB
//  usb_di_valid   out  1        usb_di valid; usb_di/valid held until usb_di_ready
//  usb_di_ready   in   1        EZ-USB accepts usb_di this cycle
//  wr_count       out  32       FIFO words written since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: all outputs 0; lane counters 0; generator value 0; divider 0; out register empty.
//  Write side: pack register + out register (ov = out register valid).
//   fifo_di = out register; fifo_wren = ov & ~fifo_full (combinational); ov clears on write.
//   Mode 0: usb_do_ready = (mode==0) & (wcnt!=RATIO-1 | ~ov | ~fifo_full).
//    Each accepted word fills lane wcnt (lane 0 = bits USB_W-1:0, LSW first); wcnt++.
//    On lane RATIO-1 the full word moves into the out register in the same edge; wcnt -> 0.
//   Modes 1/2: usb_do_ready = 0. A tick is every cycle (mode 1) or when div==rate_div (mode 2);
//    div counts 0..rate_div and then wraps.
//    On a tick with out register free or draining: out <= gen, gen <= gen+1 (FIFO_W bits, wraps).
//    A tick while blocked is dropped without loss: gen holds, so the sequence stays gap-free.
//   Mode 3: no new words. A pending out word still drains.
//   Any mode change: wcnt -> 0, div -> 0, partial packed word discarded. Out register and gen kept.
//   wr_count increments on every fifo_wren.
//  Read side: unpack shift register with rcnt = lanes remaining (0..RATIO); rp = read pending.
//   fifo_rden = (rcnt==0) & ~rp & ~fifo_empty; rp <= fifo_rden.
//   rp=1: load fifo_do; rcnt <= RATIO.
//   usb_di = lane 0; usb_di_valid = (rcnt!=0).
//   On usb_di_ready & valid: shift right by USB_W; rcnt--.
//   Throughput is RATIO words per RATIO+2 cycles; no prefetch.
//  Reset mid-operation: partial words on both sides are lost, rp cleared.
//   A fifo_do arriving the cycle after reset is ignored.
// TESTING
//  1 Mode 0, RATIO=2: push 16'h0302, 16'h0504 -> one fifo_wren, fifo_di=32'h05040302, wr_count=1.
//  2 Mode 0, fifo_full held 10 cycles with word pending -> fifo_di stable, usb_do_ready=0 on last lane,
//    no write; release -> exactly one write, no word lost or duplicated.
//  3 Mode 2, rate_div=3, 40 cycles -> 10 writes, values 0..9, spacing 4 cycles.
//    Switch to mode 1 -> one write per cycle, continuing at 10.
//  4 Read: FIFO yields 32'hAABBCCDD, usb_di_ready toggling -> usb_di 16'hCCDD then 16'hAABB, each held until ready;
//    next fifo_rden only after both accepted.
//  5 FIFO_W=64, USB_W=16: 4 words in, 1 out; mode change after 2 lanes -> partial discarded,
//    next 4 words form a clean word.
//  6 reset pulsed with rp=1 and wcnt=1 -> all outputs 0 next cycle, stale fifo_do not emitted.

Source files
------------

// File: rtl/memfifo_gearbox.sv
// memfifo_gearbox: width-converting glue between the EZ-USB port and a block-RAM FIFO.
// Write side packs RATIO USB words (LSW first) into one FIFO word, or substitutes a
// counter-pattern generator with a programmable rate. Read side unpacks FIFO words
// into USB words, lane 0 first.
//
// Handshakes: a USB-side word moves when valid & ready are both high at a rising edge
// of ifclk; valid never waits for ready, and a presented word/valid pair stays stable
// until it is taken. FIFO strobes are single-cycle requests gated by full/empty.
module memfifo_gearbox #(
    parameter int USB_W  = 16,
    parameter int FIFO_W = 32,
    parameter int DIV_W  = 4
) (
    input  logic              ifclk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [USB_W-1:0]  usb_do,
    input  logic              usb_do_valid,
    output logic              usb_do_ready,
    output logic [FIFO_W-1:0] fifo_di,
    output logic              fifo_wren,
    input  logic              fifo_full,
    input  logic [FIFO_W-1:0] fifo_do,
    output logic              fifo_rden,
    input  logic              fifo_empty,
    output logic [USB_W-1:0]  usb_di,
    output logic              usb_di_valid,
    input  logic              usb_di_ready,
    output logic [31:0]       wr_count
);

    localparam int RATIO = FIFO_W / USB_W;
    localparam int WC_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RC_W  = $clog2(RATIO + 1);
    localparam logic [WC_W-1:0] LAST_LANE = WC_W'(RATIO - 1);
    localparam logic [RC_W-1:0] FULL_RCNT = RC_W'(RATIO);

    // write-side state
    logic [1:0]        mode_q;
    logic [WC_W-1:0]   wcnt;
    logic [DIV_W-1:0]  div;
    logic [FIFO_W-1:0] pack_q;
    logic [FIFO_W-1:0] out_q;
    logic              ov;
    logic [FIFO_W-1:0] gen;
    logic [31:0]       wr_cnt_q;

    // read-side state
    logic [FIFO_W-1:0] sr_q;
    logic [RC_W-1:0]   rcnt;
    logic              rp;

    // write-side combinational helpers
    logic              mode_chg;
    logic [WC_W-1:0]   wcnt_eff;
    logic [DIV_W-1:0]  div_eff;
    logic              out_free;
    logic              last_lane;
    logic              wr_accept;
    logic              gen_tick;
    logic              gen_load;
    logic              pack_load;
    logic [FIFO_W-1:0] pack_next;

    // A mode change restarts lane and divider counting in the very cycle it is seen,
    // so the first word accepted in the new mode already lands in lane 0.
    always_comb begin
        mode_chg  = (mode != mode_q);
        wcnt_eff  = mode_chg ? '0 : wcnt;
        div_eff   = mode_chg ? '0 : div;
        out_free  = ~ov | ~fifo_full;
        last_lane = (wcnt_eff == LAST_LANE);
        usb_do_ready = ~reset & (mode == 2'd0) & (~last_lane | out_free);
        wr_accept = usb_do_valid & usb_do_ready;
        pack_load = wr_accept & last_lane;
        gen_tick  = (mode == 2'd1) | ((mode == 2'd2) & (div_eff == rate_div));
        gen_load  = gen_tick & out_free;
        pack_next = pack_q;
        pack_next[int'(wcnt_eff) * USB_W +: USB_W] = usb_do;
    end

    assign fifo_di   = out_q;
    assign fifo_wren = ov & ~fifo_full;
    assign wr_count  = wr_cnt_q;

    // Write side: lane packing, generator, out register and write counter.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            mode_q   <= 2'd0;
            wcnt     <= '0;
            div      <= '0;
            pack_q   <= '0;
            out_q    <= '0;
            ov       <= 1'b0;
            gen      <= '0;
            wr_cnt_q <= '0;
        end else begin
            mode_q <= mode;

            if (wr_accept) begin
                pack_q <= pack_next;
                wcnt   <= last_lane ? '0 : wcnt_eff + 1'b1;
            end else begin
                wcnt   <= wcnt_eff;
            end

            // Divider free-runs in mode 2 even while the out register is blocked;
            // a blocked tick simply leaves gen where it is.
            if (mode == 2'd2)
                div <= (div_eff == rate_div) ? '0 : div_eff + 1'b1;
            else
                div <= '0;

            if (pack_load) begin
                out_q <= pack_next;
                ov    <= 1'b1;
            end else if (gen_load) begin
                out_q <= gen;
                gen   <= gen + 1'b1;
                ov    <= 1'b1;
            end else if (fifo_wren) begin
                ov    <= 1'b0;
            end

            if (fifo_wren)
                wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign fifo_rden    = ~reset & (rcnt == '0) & ~rp & ~fifo_empty;
    assign usb_di       = sr_q[USB_W-1:0];
    assign usb_di_valid = (rcnt != '0);

    // Read side: fetch one FIFO word once all lanes are gone, then shift lanes out.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            sr_q <= '0;
            rcnt <= '0;
            rp   <= 1'b0;
        end else begin
            rp <= fifo_rden;
            if (rp) begin
                sr_q <= fifo_do;
                rcnt <= FULL_RCNT;
            end else if (usb_di_ready && (rcnt != '0)) begin
                sr_q <= sr_q >> USB_W;
                rcnt <= rcnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memfifo_gearbox.sv
// Bench for memfifo_gearbox: a 16/32 instance for most scenarios, a 16/64 instance
// for the wide packing case. Outputs are sampled on the falling edge, inputs are
// driven 1 time unit after the rising edge.
module tb_memfifo_gearbox;

  logic        ifclk = 0;
  logic        reset = 1;
  logic [1:0]  mode = 0;
  logic [3:0]  rate_div = 0;
  logic [15:0] usb_do = 0;
  logic        usb_do_valid = 0;
  logic        usb_do_ready;
  logic [31:0] fifo_di;
  logic        fifo_wren;
  logic        fifo_full = 0;
  logic [31:0] fifo_do;
  logic        fifo_rden;
  logic        fifo_empty;
  logic [15:0] usb_di;
  logic        usb_di_valid;
  logic        usb_di_ready = 0;
  logic [31:0] wr_count;

  logic [1:0]  mode64 = 0;
  logic [15:0] usb_do64 = 0;
  logic        usb_do_valid64 = 0;
  logic        usb_do_ready64;
  logic [63:0] fifo_di64;
  logic        fifo_wren64;
  logic [63:0] fifo_do64 = 0;
  logic        fifo_rden64;
  logic [15:0] usb_di64;
  logic        usb_di_valid64;
  logic [31:0] wr_count64;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_full = 0;
  int exp_wr = 0;

  logic [31:0] wr_obs_q[$];
  int          wr_cyc_q[$];
  logic [15:0] rd_obs_q[$];
  int          rden_cyc_q[$];
  logic [63:0] wr64_obs_q[$];
  logic [31:0] rdq[$];
  logic [31:0] exp_q[$];

  memfifo_gearbox #(.USB_W(16), .FIFO_W(32), .DIV_W(4)) u_dut (
    .ifclk(ifclk), .reset(reset), .mode(mode), .rate_div(rate_div),
    .usb_do(usb_do), .usb_do_valid(usb_do_valid), .usb_do_ready(usb_do_ready),
    .fifo_di(fifo_di), .fifo_wren(fifo_wren), .fifo_full(fifo_full),
    .fifo_do(fifo_do), .fifo_rden(fifo_rden), .fifo_empty(fifo_empty),
    .usb_di(usb_di), .usb_di_valid(usb_di_valid), .usb_di_ready(usb_di_ready),
    .wr_count(wr_count)
  );

  memfifo_gearbox #(.USB_W(16), .FIFO_W(64), .DIV_W(4)) u_dut64 (
    .ifclk(ifclk), .reset(reset), .mode(mode64), .rate_div(rate_div),
    .usb_do(usb_do64), .usb_do_valid(usb_do_valid64), .usb_do_ready(usb_do_ready64),
    .fifo_di(fifo_di64), .fifo_wren(fifo_wren64), .fifo_full(1'b0),
    .fifo_do(fifo_do64), .fifo_rden(fifo_rden64), .fifo_empty(1'b1),
    .usb_di(usb_di64), .usb_di_valid(usb_di_valid64), .usb_di_ready(1'b0),
    .wr_count(wr_count64)
  );

  // clock and cycle counter
  initial forever #5 ifclk = ~ifclk;
  initial forever begin @(posedge ifclk); cyc++; end

  // output monitors
  initial forever begin
    @(negedge ifclk);
    if (fifo_wren === 1'b1) begin wr_obs_q.push_back(fifo_di); wr_cyc_q.push_back(cyc); end
    if (usb_di_valid === 1'b1 && usb_di_ready === 1'b1) rd_obs_q.push_back(usb_di);
    if (fifo_rden === 1'b1) rden_cyc_q.push_back(cyc);
    if (fifo_wren64 === 1'b1) wr64_obs_q.push_back(fifo_di64);
  end

  // FIFO read model: data appears the cycle after the read strobe
  initial begin
    bit rd_req;
    fifo_do = 0;
    fifo_empty = 1;
    forever begin
      @(negedge ifclk);
      rd_req = (fifo_rden === 1'b1);
      @(posedge ifclk); #1;
      if (rd_req && rdq.size() > 0) fifo_do = rdq.pop_front();
      fifo_empty = (rdq.size() == 0);
    end
  end

  task automatic step();
    @(posedge ifclk); #1;
  endtask

  task automatic usb_push(input bit wide, input logic [15:0] w, output bit ok);
    bit acc;
    ok = 0;
    if (wide) begin usb_do64 = w; usb_do_valid64 = 1; end
    else begin usb_do = w; usb_do_valid = 1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge ifclk);
      acc = wide ? usb_do_ready64 : usb_do_ready;
      @(posedge ifclk); #1;
      if (acc) ok = 1;
      if (rand_full) fifo_full = ($urandom_range(0, 2) == 0);
    end
    usb_do_valid = 0;
    usb_do_valid64 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) step();
    @(negedge ifclk);
    checks++; if (usb_do_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b expected 0", usb_do_ready); end
    checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL rst_wren_in_reset: got %b expected 0", fifo_wren); end
    step();
    reset = 0;
    @(negedge ifclk);
    checks++; if (fifo_di !== 32'h0) begin errors++; $display("FAIL rst_fifo_di: got %h expected 0", fifo_di); end
    checks++; if (usb_di_valid !== 1'b0) begin errors++; $display("FAIL rst_usb_di_valid: got %b expected 0", usb_di_valid); end
    checks++; if (usb_di !== 16'h0) begin errors++; $display("FAIL rst_usb_di: got %h expected 0", usb_di); end
    checks++; if (wr_count !== 32'h0) begin errors++; $display("FAIL rst_wr_count: got %0d expected 0", wr_count); end
    checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL rst_fifo_rden: got %b expected 0", fifo_rden); end
    checks++; if (usb_do_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_mode0: got %b expected 1", usb_do_ready); end
    step();
  endtask

  task automatic test_pack();
    bit ok0, ok1;
    wr_obs_q.delete();
    usb_push(0, 16'h0302, ok0);
    usb_push(0, 16'h0504, ok1);
    repeat (3) step();
    exp_wr += 1;
    checks++; if (!(ok0 && ok1)) begin errors++; $display("FAIL pack_accept: got %b%b expected 11", ok0, ok1); end
    checks++; if (wr_obs_q.size() != 1) begin errors++; $display("FAIL pack_writes: got %0d expected 1", wr_obs_q.size()); end
    else begin
      checks++; if (wr_obs_q[0] !== 32'h05040302) begin errors++; $display("FAIL pack_data: got %h expected 05040302", wr_obs_q[0]); end
    end
    checks++; if (wr_count !== 32'(exp_wr)) begin errors++; $display("FAIL pack_wr_count: got %0d expected %0d", wr_count, exp_wr); end
  endtask

  task automatic test_full_backpressure();
    logic [15:0] w[4];
    bit ok;
    logic [31:0] held;
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    held = {w[1], w[0]};
    wr_obs_q.delete();
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      usb_push(0, w[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_push%0d: got timeout expected accept", i); end
    end
    usb_do = w[3];
    usb_do_valid = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge ifclk);
      checks++; if (usb_do_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b expected 0", c, usb_do_ready); end
      checks++; if (fifo_di !== held) begin errors++; $display("FAIL bp_di_stable c%0d: got %h expected %h", c, fifo_di, held); end
      checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL bp_no_write c%0d: got %b expected 0", c, fifo_wren); end
      step();
    end
    fifo_full = 0;
    usb_push(0, w[3], ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_push3: got timeout expected accept"); end
    repeat (3) step();
    exp_wr += 2;
    checks++; if (wr_obs_q.size() != 2) begin errors++; $display("FAIL bp_writes: got %0d expected 2", wr_obs_q.size()); end
    else begin
      checks++; if (wr_obs_q[0] !== held) begin errors++; $display("FAIL bp_word0: got %h expected %h", wr_obs_q[0], held); end
      checks++; if (wr_obs_q[1] !== {w[3], w[2]}) begin errors++; $display("FAIL bp_word1: got %h expected %h", wr_obs_q[1], {w[3], w[2]}); end
    end
    checks++; if (wr_count !== 32'(exp_wr)) begin errors++; $display("FAIL bp_wr_count: got %0d expected %0d", wr_count, exp_wr); end
  endtask

  task automatic test_random_pack();
    logic [15:0] lo;
    logic [15:0] w;
    bit ok;
    wr_obs_q.delete();
    exp_q.delete();
    rand_full = 1;
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      usb_push(0, w, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_push%0d: got timeout expected accept", i); end
      if (i % 2 == 0) lo = w;
      else exp_q.push_back({w, lo});
      repeat ($urandom_range(0, 2)) step();
    end
    rand_full = 0;
    fifo_full = 0;
    repeat (4) step();
    exp_wr += exp_q.size();
    checks++; if (wr_obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_writes: got %0d expected %0d", wr_obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_obs_q.size(); i++) begin
      checks++; if (wr_obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word%0d: got %h expected %h", i, wr_obs_q[i], exp_q[i]); end
    end
    checks++; if (wr_count !== 32'(exp_wr)) begin errors++; $display("FAIL rnd_wr_count: got %0d expected %0d", wr_count, exp_wr); end
  endtask

  task automatic test_generator();
    wr_obs_q.delete();
    wr_cyc_q.delete();
    fifo_full = 0;
    rate_div = 4'd3;
    mode = 2'd2;
    repeat (40) step();
    mode = 2'd1;
    repeat (12) step();
    mode = 2'd3;
    repeat (4) step();
    exp_wr += 22;
    checks++; if (wr_obs_q.size() != 22) begin errors++; $display("FAIL gen_writes: got %0d expected 22", wr_obs_q.size()); end
    for (int i = 0; i < 22 && i < wr_obs_q.size(); i++) begin
      checks++; if (wr_obs_q[i] !== 32'(i)) begin errors++; $display("FAIL gen_value%0d: got %0d expected %0d", i, wr_obs_q[i], i); end
      if (i > 0) begin
        checks++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != ((i < 10) ? 4 : 1)) begin
          errors++; $display("FAIL gen_spacing%0d: got %0d expected %0d", i, wr_cyc_q[i] - wr_cyc_q[i-1], (i < 10) ? 4 : 1);
        end
      end
    end
    checks++; if (wr_count !== 32'(exp_wr)) begin errors++; $display("FAIL gen_wr_count: got %0d expected %0d", wr_count, exp_wr); end
  endtask

  task automatic test_unpack(input bit fixed_pat, input int nwords);
    logic [31:0] w;
    logic [15:0] exp_lanes[$];
    logic        prev_valid, prev_ready;
    logic [15:0] prev_di;
    rd_obs_q.delete();
    usb_di_ready = 0;
    for (int i = 0; i < nwords; i++) begin
      w = fixed_pat ? ((i == 0) ? 32'hAABBCCDD : 32'h11223344) : $urandom;
      rdq.push_back(w);
      exp_lanes.push_back(w[15:0]);
      exp_lanes.push_back(w[31:16]);
    end
    prev_valid = 0; prev_ready = 0; prev_di = 0;
    for (int c = 0; c < 400 && rd_obs_q.size() < exp_lanes.size(); c++) begin
      @(negedge ifclk);
      if (prev_valid && !prev_ready) begin
        checks++;
        if (usb_di_valid !== 1'b1 || usb_di !== prev_di) begin
          errors++; $display("FAIL rd_hold: got %b/%h expected 1/%h", usb_di_valid, usb_di, prev_di);
        end
      end
      if (fifo_rden === 1'b1) begin
        checks++; if (usb_di_valid !== 1'b0) begin errors++; $display("FAIL rd_early_rden: got valid %b expected 0", usb_di_valid); end
      end
      prev_valid = usb_di_valid; prev_ready = usb_di_ready; prev_di = usb_di;
      step();
      usb_di_ready = fixed_pat ? ~usb_di_ready : 1'($urandom_range(0, 1));
    end
    usb_di_ready = 0;
    checks++; if (rd_obs_q.size() != exp_lanes.size()) begin errors++; $display("FAIL rd_lanes: got %0d expected %0d", rd_obs_q.size(), exp_lanes.size()); end
    for (int i = 0; i < exp_lanes.size() && i < rd_obs_q.size(); i++) begin
      checks++; if (rd_obs_q[i] !== exp_lanes[i]) begin errors++; $display("FAIL rd_lane%0d: got %h expected %h", i, rd_obs_q[i], exp_lanes[i]); end
    end
  endtask

  task automatic test_read_throughput();
    rd_obs_q.delete();
    rden_cyc_q.delete();
    usb_di_ready = 1;
    for (int i = 0; i < 4; i++) rdq.push_back($urandom);
    for (int c = 0; c < 200 && rd_obs_q.size() < 8; c++) step();
    usb_di_ready = 0;
    checks++; if (rden_cyc_q.size() != 4) begin errors++; $display("FAIL tp_rden_count: got %0d expected 4", rden_cyc_q.size()); end
    for (int i = 1; i < rden_cyc_q.size(); i++) begin
      checks++; if (rden_cyc_q[i] - rden_cyc_q[i-1] != 4) begin errors++; $display("FAIL tp_rden_spacing%0d: got %0d expected 4", i, rden_cyc_q[i] - rden_cyc_q[i-1]); end
    end
  endtask

  task automatic test_wide();
    logic [15:0] w[4];
    logic [63:0] exp0, exp1;
    bit ok;
    wr64_obs_q.delete();
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    exp0 = {w[3], w[2], w[1], w[0]};
    for (int i = 0; i < 4; i++) begin
      usb_push(1, w[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL wide_push%0d: got timeout expected accept", i); end
    end
    usb_push(1, 16'hBAD0, ok);
    usb_push(1, 16'hBAD1, ok);
    mode64 = 2'd3;
    repeat (2) step();
    mode64 = 2'd0;
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    exp1 = {w[3], w[2], w[1], w[0]};
    for (int i = 0; i < 4; i++) begin
      usb_push(1, w[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL wide_push2_%0d: got timeout expected accept", i); end
    end
    repeat (3) step();
    checks++; if (wr64_obs_q.size() != 2) begin errors++; $display("FAIL wide_writes: got %0d expected 2", wr64_obs_q.size()); end
    else begin
      checks++; if (wr64_obs_q[0] !== exp0) begin errors++; $display("FAIL wide_word0: got %h expected %h", wr64_obs_q[0], exp0); end
      checks++; if (wr64_obs_q[1] !== exp1) begin errors++; $display("FAIL wide_word1: got %h expected %h", wr64_obs_q[1], exp1); end
    end
    checks++; if (wr_count64 !== 32'd2) begin errors++; $display("FAIL wide_wr_count: got %0d expected 2", wr_count64); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    mode = 2'd0;
    fifo_full = 0;
    usb_di_ready = 0;
    step();
    usb_push(0, 16'hDEAD, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_push: got timeout expected accept"); end
    rdq.push_back(32'h12345678);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge ifclk);
      if (fifo_rden === 1'b1) seen = 1;
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_rden: got no read expected a read"); end
    reset = 1;
    step();
    reset = 0;
    wr_obs_q.delete();
    rd_obs_q.delete();
    @(negedge ifclk);
    checks++; if (usb_di_valid !== 1'b0) begin errors++; $display("FAIL rm_usb_di_valid: got %b expected 0", usb_di_valid); end
    checks++; if (usb_di !== 16'h0) begin errors++; $display("FAIL rm_usb_di: got %h expected 0", usb_di); end
    checks++; if (fifo_wren !== 1'b0) begin errors++; $display("FAIL rm_fifo_wren: got %b expected 0", fifo_wren); end
    checks++; if (fifo_di !== 32'h0) begin errors++; $display("FAIL rm_fifo_di: got %h expected 0", fifo_di); end
    checks++; if (wr_count !== 32'h0) begin errors++; $display("FAIL rm_wr_count: got %0d expected 0", wr_count); end
    usb_di_ready = 1;
    repeat (6) step();
    usb_di_ready = 0;
    checks++; if (rd_obs_q.size() != 0) begin errors++; $display("FAIL rm_stale_read: got %0d lanes expected 0", rd_obs_q.size()); end
    usb_push(0, 16'hBEEF, ok);
    usb_push(0, 16'hCAFE, ok);
    repeat (3) step();
    checks++; if (wr_obs_q.size() != 1) begin errors++; $display("FAIL rm_writes: got %0d expected 1", wr_obs_q.size()); end
    else begin
      checks++; if (wr_obs_q[0] !== 32'hCAFEBEEF) begin errors++; $display("FAIL rm_word: got %h expected cafebeef", wr_obs_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_full_backpressure();
    test_random_pack();
    test_generator();
    test_unpack(1, 2);
    test_unpack(0, 6);
    test_read_throughput();
    test_wide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
